audio_sample_sink: RTL and testbench

Consumer end of the processor's audio handshake. Accepts 11-bit samples posted by the pipeline on `R6_audio` under a four-phase req/ack handshake (`R14_flag` = request, returned `R13_flag` = acknowledge). Buffers the samples in a small FIFO and replays them as a PWM audio stream at a fixed sample period. Sits at top level between `datapath` and the board audio pin, clocked directly by `clkFPGA`.

---
 rtl/audio_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/audio_sample_sink.sv | 181 ++++++++++++++++++
 tb/tb_audio_sample_sink.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio sample sink: sample width, PWM
// period, midscale silence level and the handshake state encoding.
package audio_pkg;

    localparam int SAMPLE_W   = 11;
    localparam int PWM_PERIOD = 2048;

    localparam logic [SAMPLE_W-1:0] MIDSCALE = 11'd1024;
    localparam logic [SAMPLE_W-1:0] CNT_MAX  = SAMPLE_W'(PWM_PERIOD - 1);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } sink_state_t;

    // Saturating 16-bit increment used by event counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; pushes when full and pops when
// empty are silently dropped so the caller never corrupts the occupancy.
module sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Read and write pointer advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Sample storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

    assign dout  = mem_r[rd_ptr_r[AW-1:0]];
    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign level = wr_ptr_r - rd_ptr_r;

endmodule

// File: rtl/audio_sample_sink.sv
// Consumer side of the processor audio req/ack handshake: queues samples and
// replays them as PWM. Optional underrun counter: AUDIO_SINK_UNDERRUN_CNT_EN.
module audio_sample_sink
    import audio_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int PWM_REPEAT = 1
) (
    input  logic                     clkFPGA,
    input  logic                     rst,
    input  logic [SAMPLE_W-1:0]      sample_in,
    input  logic                     req_in,
    input  logic                     finish_in,
    output logic                     ack_out,
    output logic                     pwm_out,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     drained
`ifdef AUDIO_SINK_UNDERRUN_CNT_EN
    ,
    output logic [15:0]              underrun_cnt
`endif
);

    localparam int REP_W = (PWM_REPEAT > 1) ? $clog2(PWM_REPEAT) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(PWM_REPEAT - 1);

    logic req_meta_r;
    logic req_s;
    logic fin_meta_r;
    logic fin_s;

    sink_state_t state_r;
    sink_state_t state_next_s;
    logic        push_s;
    logic        ack_r;

    logic [SAMPLE_W-1:0] cnt_r;
    logic [REP_W-1:0]    rep_r;
    logic [SAMPLE_W-1:0] cur_r;
    logic                pwm_r;
    logic                boundary_s;
    logic                pop_s;

    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [SAMPLE_W-1:0] fifo_dout_s;

    logic fin_l_r;
    logic drained_r;

    // Two-flop synchronizers for the processor-clock-domain strobes.
    always_ff @(posedge clkFPGA or negedge rst) begin
        if (!rst) begin
            req_meta_r <= 1'b0;
            req_s      <= 1'b0;
            fin_meta_r <= 1'b0;
            fin_s      <= 1'b0;
        end else begin
            req_meta_r <= req_in;
            req_s      <= req_meta_r;
            fin_meta_r <= finish_in;
            fin_s      <= fin_meta_r;
        end
    end

    // Handshake state and registered acknowledge.
    always_ff @(posedge clkFPGA or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            ack_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ack_r   <= (state_next_s == ACK);
        end
    end

    // Next-state: a full FIFO holds the request off in IDLE until space frees.
    always_comb begin
        state_next_s = state_r;
        push_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s && !fifo_full_s) begin
                    push_s       = 1'b1;
                    state_next_s = ACK;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACK: begin
                if (!req_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = ACK;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    sync_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clkFPGA),
        .rst_n (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (sample_in),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level)
    );

    // An empty FIFO at the boundary (even one being pushed this cycle) is an underrun.
    assign boundary_s = (cnt_r == CNT_MAX) && (rep_r == REP_LAST);
    assign pop_s      = boundary_s & ~fifo_empty_s;

    // PWM period and repeat counters, current sample and comparator output.
    always_ff @(posedge clkFPGA or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
            rep_r <= '0;
            cur_r <= MIDSCALE;
            pwm_r <= 1'b0;
        end else begin
            cnt_r <= cnt_r + 11'd1;
            if (cnt_r == CNT_MAX) begin
                if (rep_r == REP_LAST) begin
                    rep_r <= '0;
                end else begin
                    rep_r <= rep_r + 1'b1;
                end
            end
            if (pop_s) begin
                cur_r <= fifo_dout_s;
            end
            pwm_r <= (cnt_r < cur_r);
        end
    end

    // Sticky finish latch and drained flag.
    always_ff @(posedge clkFPGA or negedge rst) begin
        if (!rst) begin
            fin_l_r   <= 1'b0;
            drained_r <= 1'b0;
        end else begin
            fin_l_r   <= fin_l_r | fin_s;
            drained_r <= drained_r |
                         (fin_l_r & fifo_empty_s & (state_r == IDLE) & ~req_s);
        end
    end

`ifdef AUDIO_SINK_UNDERRUN_CNT_EN
    logic        underrun_s;
    logic [15:0] underrun_cnt_r;

    assign underrun_s = boundary_s & fifo_empty_s;

    // Saturating count of boundaries that found nothing to play.
    always_ff @(posedge clkFPGA or negedge rst) begin
        if (!rst) begin
            underrun_cnt_r <= 16'd0;
        end else if (underrun_s) begin
            underrun_cnt_r <= sat_inc16(underrun_cnt_r);
        end else begin
            underrun_cnt_r <= underrun_cnt_r;
        end
    end

    assign underrun_cnt = underrun_cnt_r;
`endif

    assign ack_out = ack_r;
    assign pwm_out = pwm_r;
    assign drained = drained_r;

endmodule

// File: tb/tb_audio_sample_sink.sv
// Self-checking bench for audio_sample_sink (DEPTH=16, PWM_REPEAT=2) with a
// queue-based model of what each sample period should play.
module tb_audio_sample_sink;

    localparam int DEPTH  = 16;
    localparam int REP    = 2;
    localparam int PERIOD = 2048;
    localparam int SP     = PERIOD * REP;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] sample_in = 11'd0;
    logic        req_in = 1'b0;
    logic        finish_in = 1'b0;
    wire         ack_out;
    wire         pwm_out;
    wire  [4:0]  fifo_level;
    wire         drained;
`ifdef AUDIO_SINK_UNDERRUN_CNT_EN
    wire  [15:0] underrun_cnt;
`endif

    int total = 0;
    int bad = 0;
    int cyc;

    int unsigned exp_q[$];
    int unsigned model_cur;
    int unsigned model_underruns;

    audio_sample_sink #(
        .DEPTH      (DEPTH),
        .PWM_REPEAT (REP)
    ) dut (
        .clkFPGA    (clk),
        .rst        (rst),
        .sample_in  (sample_in),
        .req_in     (req_in),
        .finish_in  (finish_in),
        .ack_out    (ack_out),
        .pwm_out    (pwm_out),
        .fifo_level (fifo_level),
        .drained    (drained)
`ifdef AUDIO_SINK_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    // Model: what a sample boundary does to the played value.
    task automatic model_boundary;
        if (exp_q.size() > 0) model_cur = exp_q.pop_front();
        else model_underruns++;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        req_in = 1'b0;
        finish_in = 1'b0;
        sample_in = 11'd0;
        exp_q.delete();
        model_cur = 1024;
        model_underruns = 0;
        repeat (3) tick();
        rst = 1'b1;
    endtask

    task automatic measure(input int n, output int highs);
        highs = 0;
        repeat (n) begin
            tick();
            if (pwm_out === 1'b1) highs++;
        end
    endtask

    // Full four-phase handshake; latencies are -1 when the bound expires.
    task automatic post(input logic [10:0] v, input int bound, output int rise, output int fall);
        int start;
        sample_in = v;
        req_in = 1'b1;
        start = cyc;
        rise = -1;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (ack_out === 1'b1) begin
                rise = cyc - start;
                break;
            end
        end
        req_in = 1'b0;
        start = cyc;
        fall = -1;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (ack_out === 1'b0) begin
                fall = cyc - start;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) tick();
        total++;
        if (ack_out !== 1'b0 || pwm_out !== 1'b0 || fifo_level !== 5'd0 || drained !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got ack=%b pwm=%b level=%0d drained=%b exp 0/0/0/0",
                     ack_out, pwm_out, fifo_level, drained);
        end
`ifdef AUDIO_SINK_UNDERRUN_CNT_EN
        total++;
        if (underrun_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_underrun got=%0d exp=0", underrun_cnt);
        end
`endif
    endtask

    task automatic test_idle;
        int h;
        do_reset();
        measure(PERIOD, h);
        total++;
        if (h != 1024) begin
            bad++;
            $display("FAIL idle_high got=%0d exp=1024", h);
        end
        total++;
        if (ack_out !== 1'b0 || fifo_level !== 5'd0) begin
            bad++;
            $display("FAIL idle_ack got ack=%b level=%0d exp 0/0", ack_out, fifo_level);
        end
    endtask

    // Continues from test_idle at cycle 2048, no reset in between.
    task automatic test_single_handshake;
        int r, f, h;
        post(11'd512, 20, r, f);
        exp_q.push_back(512);
        total++;
        if (r != 3) begin bad++; $display("FAIL hs_rise_latency got=%0d exp=3", r); end
        total++;
        if (f != 3) begin bad++; $display("FAIL hs_fall_latency got=%0d exp=3", f); end
        total++;
        if (fifo_level !== 5'(exp_q.size())) begin
            bad++;
            $display("FAIL hs_level got=%0d exp=%0d", fifo_level, exp_q.size());
        end
        wait_until(SP);
        model_boundary();
        total++;
        if (fifo_level !== 5'(exp_q.size())) begin
            bad++;
            $display("FAIL hs_level_pop got=%0d exp=%0d", fifo_level, exp_q.size());
        end
        for (int p = 0; p < REP; p++) begin
            measure(PERIOD, h);
            total++;
            if (h != int'(model_cur)) begin
                bad++;
                $display("FAIL hs_play period=%0d got=%0d exp=%0d", p, h, model_cur);
            end
        end
        model_boundary();
        measure(PERIOD, h);
        total++;
        if (h != int'(model_cur)) begin
            bad++;
            $display("FAIL hs_underrun_hold got=%0d exp=%0d", h, model_cur);
        end
`ifdef AUDIO_SINK_UNDERRUN_CNT_EN
        total++;
        if (underrun_cnt !== 16'(model_underruns)) begin
            bad++;
            $display("FAIL hs_underrun_cnt got=%0d exp=%0d", underrun_cnt, model_underruns);
        end
`endif
        total++;
        if (drained !== 1'b0) begin
            bad++;
            $display("FAIL hs_no_finish_drained got=%b exp=0", drained);
        end
    endtask

    task automatic test_full;
        int r, f, h, s;
        logic [10:0] v;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            v = 11'($urandom_range(0, 2047));
            repeat ($urandom_range(0, 3)) tick();
            post(v, 20, r, f);
            exp_q.push_back(int'(v));
            total++;
            if (r != 3 || f != 3) begin
                bad++;
                $display("FAIL full_fill_latency idx=%0d got=%0d/%0d exp=3/3", i, r, f);
            end
        end
        total++;
        if (fifo_level !== 5'(exp_q.size())) begin
            bad++;
            $display("FAIL full_level got=%0d exp=%0d", fifo_level, exp_q.size());
        end
        v = 11'($urandom_range(0, 2047));
        s = cyc;
        post(v, SP + 100, r, f);
        model_boundary();
        exp_q.push_back(int'(v));
        total++;
        if (r != SP + 1 - s) begin
            bad++;
            $display("FAIL full_stall_rise got=%0d exp=%0d", r, SP + 1 - s);
        end
        total++;
        if (fifo_level !== 5'(exp_q.size())) begin
            bad++;
            $display("FAIL full_level_after got=%0d exp=%0d", fifo_level, exp_q.size());
        end
        wait_until(SP + PERIOD);
        measure(PERIOD, h);
        total++;
        if (h != int'(model_cur)) begin
            bad++;
            $display("FAIL full_first_play got=%0d exp=%0d", h, model_cur);
        end
    endtask

    task automatic test_extremes_finish;
        int r, f, h;
        int unsigned vals[3];
        vals[0] = 0;
        vals[1] = 2047;
        vals[2] = 300;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            post(11'(vals[i]), 20, r, f);
            exp_q.push_back(vals[i]);
            total++;
            if (r != 3 || f != 3) begin
                bad++;
                $display("FAIL ext_latency idx=%0d got=%0d/%0d exp=3/3", i, r, f);
            end
        end
        finish_in = 1'b1;
        repeat (4) tick();
        finish_in = 1'b0;
        total++;
        if (drained !== 1'b0) begin
            bad++;
            $display("FAIL ext_drained_early got=%b exp=0", drained);
        end
        wait_until(SP);
        for (int b = 0; b < 2; b++) begin
            model_boundary();
            for (int p = 0; p < REP; p++) begin
                measure(PERIOD, h);
                total++;
                if (h != int'(model_cur)) begin
                    bad++;
                    $display("FAIL ext_play sample=%0d period=%0d got=%0d exp=%0d", b, p, h, model_cur);
                end
            end
        end
        model_boundary();
        total++;
        if (drained !== 1'b0 || fifo_level !== 5'd0) begin
            bad++;
            $display("FAIL ext_last_pop got drained=%b level=%0d exp 0/0", drained, fifo_level);
        end
        tick();
        total++;
        if (drained !== 1'b1) begin
            bad++;
            $display("FAIL ext_drained_rise got=%b exp=1", drained);
        end
        wait_until(3 * SP + PERIOD);
        measure(PERIOD, h);
        total++;
        if (h != int'(model_cur)) begin
            bad++;
            $display("FAIL ext_play_300 got=%0d exp=%0d", h, model_cur);
        end
        model_boundary();
        measure(PERIOD, h);
        total++;
        if (h != int'(model_cur)) begin
            bad++;
            $display("FAIL ext_underrun_hold got=%0d exp=%0d", h, model_cur);
        end
`ifdef AUDIO_SINK_UNDERRUN_CNT_EN
        total++;
        if (underrun_cnt !== 16'(model_underruns)) begin
            bad++;
            $display("FAIL ext_underrun_cnt1 got=%0d exp=%0d", underrun_cnt, model_underruns);
        end
        wait_until(5 * SP);
        model_boundary();
        total++;
        if (underrun_cnt !== 16'(model_underruns)) begin
            bad++;
            $display("FAIL ext_underrun_cnt2 got=%0d exp=%0d", underrun_cnt, model_underruns);
        end
`endif
        total++;
        if (drained !== 1'b1) begin
            bad++;
            $display("FAIL ext_drained_sticky got=%b exp=1", drained);
        end
    endtask

    task automatic test_reset_in_ack;
        bit seen;
        do_reset();
        sample_in = 11'($urandom_range(0, 2047));
        req_in = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ack_out === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL rack_ack_rise got=0 exp=1");
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (ack_out !== 1'b0 || fifo_level !== 5'd0 || pwm_out !== 1'b0) begin
            bad++;
            $display("FAIL rack_async got ack=%b level=%0d pwm=%b exp 0/0/0",
                     ack_out, fifo_level, pwm_out);
        end
        req_in = 1'b0;
        tick();
        rst = 1'b1;
        repeat (6) tick();
        total++;
        if (ack_out !== 1'b0 || fifo_level !== 5'd0) begin
            bad++;
            $display("FAIL rack_after got ack=%b level=%0d exp 0/0", ack_out, fifo_level);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_handshake();
        test_full();
        test_extremes_finish();
        test_reset_in_ack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
